// File: rtl/unpack_and_expand_pkg.sv
// ---------------------------------------------------------------------------
// unpack_and_expand_pkg
// Shared types and helpers for the unpack-and-expand block.
//   state_t          : control FSM states (IDLE / COLLECT / HOLD)
//   PREC_W           : width of a precision code
//   SEL_INT*         : typed copies of the shared precision codes
//   elem_bits        : element size in bits for a code (0 = invalid code)
//   elems_per_word   : elements carried by one packed word (0 = invalid)
//   words_per_vector : packed words needed to fill all lanes (1 if invalid)
// ---------------------------------------------------------------------------
package unpack_and_expand_pkg;

`include "precision_def.sv"

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam int PREC_W = `LOG_ALLOWED_PRECISIONS;

    localparam logic [PREC_W-1:0] SEL_INT8  = `INT8;
    localparam logic [PREC_W-1:0] SEL_INT16 = `INT16;
    localparam logic [PREC_W-1:0] SEL_INT32 = `INT32;
    localparam logic [PREC_W-1:0] SEL_INT64 = `INT64;

    function automatic int elem_bits(input logic [PREC_W-1:0] sel);
        case (sel)
            `INT8:   return 8;
            `INT16:  return 16;
            `INT32:  return 32;
            `INT64:  return 64;
            default: return 0;
        endcase
    endfunction

    function automatic int elems_per_word(input logic [PREC_W-1:0] sel, input int dw);
        int bits;
        bits = elem_bits(sel);
        if (bits == 0 || bits > dw) return 0;
        return dw / bits;
    endfunction

    // An invalid code still consumes exactly one word.
    function automatic int words_per_vector(input logic [PREC_W-1:0] sel, input int dw,
                                            input int lanes);
        int e;
        e = elems_per_word(sel, dw);
        if (e == 0) return 1;
        return (lanes + e - 1) / e;
    endfunction

endpackage

// File: rtl/precision_def.sv
// ---------------------------------------------------------------------------
// precision_def
// Shared precision-code definitions used by the compactor / expander pair.
//   LOG_ALLOWED_PRECISIONS : width of a precision code
//   INT8 / INT16 / INT32 / INT64 : legal codes; all other codes are invalid
// ---------------------------------------------------------------------------
`ifndef PRECISION_DEF_VH
`define PRECISION_DEF_VH

`define LOG_ALLOWED_PRECISIONS 3
`define INT8  3'd0
`define INT16 3'd1
`define INT32 3'd2
`define INT64 3'd3

`endif

// File: rtl/unpack_and_expand_element.sv
// ---------------------------------------------------------------------------
// element_extend
// Extracts element idx from a packed word at the given precision and
// extends it to data_width bits.
//   word     : packed word, element 0 in the LSBs
//   idx      : element index within the word
//   sel      : precision code
//   sign_ext : 1 = sign-extend, 0 = zero-extend
//   value    : extended element (zero for an invalid code)
// ---------------------------------------------------------------------------
module element_extend
    import unpack_and_expand_pkg::*;
#(
    parameter int data_width = 64,
    parameter int idx_w      = 3
) (
    input  logic [data_width-1:0] word,
    input  logic [idx_w-1:0]      idx,
    input  logic [PREC_W-1:0]     sel,
    input  logic                  sign_ext,
    output logic [data_width-1:0] value
);

    int                  bits;
    logic [data_width-1:0] shifted;
    logic [data_width-1:0] mask;
    logic [data_width-1:0] msb;

    always_comb begin
        bits    = elem_bits(sel);
        shifted = '0;
        mask    = '0;
        msb     = '0;
        value   = '0;
        if (bits != 0 && bits <= data_width) begin
            shifted = word >> (int'(idx) * bits);
            // mask covers the low 'bits' bits; msb isolates the element's sign bit
            mask    = {data_width{1'b1}} >> (data_width - bits);
            msb     = mask & ~(mask >> 1);
            value   = shifted & mask;
            if (sign_ext && |(shifted & msb)) value = value | ~mask;
        end
    end

endmodule

// File: rtl/unpack_and_expand.sv
// ---------------------------------------------------------------------------
// unpack_and_expand
// Inverse of the precision compactor: collects packed words of P-bit
// elements and spreads them one element per output lane, extended to
// data_width bits.
//   clk, aresetn : clock, asynchronous active-low reset
//   data_select  : precision code, latched with the first word of a vector
//   signed_mode  : 1 = sign-extend, 0 = zero-extend, latched likewise
//   s_valid/s_ready/s_data : packed word input handshake
//   m_valid/m_ready/m_data : expanded vector output, lane i at i*data_width
//   busy         : high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module unpack_and_expand
    import unpack_and_expand_pkg::*;
#(
    parameter int K          = 4,
    parameter int data_width = 64
) (
    input  logic                    clk,
    input  logic                    aresetn,
    input  logic [PREC_W-1:0]       data_select,
    input  logic                    signed_mode,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [data_width-1:0]   s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [K*data_width-1:0] m_data,
    output logic                    busy
);

    localparam int CNT_W = (K > 1) ? $clog2(K + 1) : 1;
    localparam int IDX_W = (data_width / 8 > 1) ? $clog2(data_width / 8) : 1;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    w_cnt;
    logic [PREC_W-1:0]   sel_q;
    logic                sgn_q;
    logic                rdy_en;

    logic [PREC_W-1:0]   cur_sel;
    logic                cur_sgn;
    int                  n_words;
    int                  epw;
    logic                last_word;
    logic                accept;

    // s_ready stays low until the first clock edge after reset release.
    assign s_ready = rdy_en && (state != HOLD);
    assign m_valid = (state == HOLD);
    assign busy    = (state != IDLE);
    assign accept  = s_valid && s_ready;

    // In IDLE the live inputs describe the word being accepted; afterwards
    // the latched copies govern the rest of the vector.
    always_comb begin
        cur_sel   = (state == IDLE) ? data_select : sel_q;
        cur_sgn   = (state == IDLE) ? signed_mode : sgn_q;
        n_words   = words_per_vector(cur_sel, data_width, K);
        epw       = elems_per_word(cur_sel, data_width);
        last_word = (int'(w_cnt) == n_words - 1);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = last_word ? HOLD : COLLECT;
            COLLECT: if (accept && last_word) state_nxt = HOLD;
            HOLD:    if (m_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state  <= IDLE;
            w_cnt  <= '0;
            sel_q  <= '0;
            sgn_q  <= 1'b0;
            rdy_en <= 1'b0;
        end else begin
            state  <= state_nxt;
            rdy_en <= 1'b1;
            if (accept) w_cnt <= last_word ? '0 : w_cnt + 1'b1;
            if (accept && state == IDLE) begin
                sel_q <= data_select;
                sgn_q <= signed_mode;
            end
        end
    end

    genvar i;
    generate
        for (i = 0; i < K; i = i + 1) begin : g_lane
            int                    j_off;
            logic                  hit;
            logic [IDX_W-1:0]      idx;
            logic [data_width-1:0] ext;
            logic [data_width-1:0] lane_q;

            // Lane i takes element (i - w*E) of the current word when in range;
            // lanes past the last element are never hit and stay cleared.
            always_comb begin
                j_off = i - int'(w_cnt) * epw;
                hit   = (j_off >= 0) && (j_off < epw);
                idx   = hit ? IDX_W'(j_off) : '0;
            end

            element_extend #(
                .data_width (data_width),
                .idx_w      (IDX_W)
            ) u_ext (
                .word     (s_data),
                .idx      (idx),
                .sel      (cur_sel),
                .sign_ext (cur_sgn),
                .value    (ext)
            );

            // The first word of a vector clears every lane it does not write.
            always_ff @(posedge clk or negedge aresetn) begin
                if (!aresetn) begin
                    lane_q <= '0;
                end else if (accept) begin
                    if (hit)                lane_q <= ext;
                    else if (state == IDLE) lane_q <= '0;
                end
            end

            assign m_data[i*data_width +: data_width] = lane_q;
        end
    endgenerate

endmodule

// File: tb/tb_unpack_and_expand.sv
module tb_unpack_and_expand;
    import unpack_and_expand_pkg::*;

    localparam int K  = 4;
    localparam int DW = 64;
    localparam int VW = K * DW;

    logic              clk;
    logic              aresetn;
    logic [PREC_W-1:0] data_select;
    logic              signed_mode;
    logic              s_valid;
    logic              s_ready;
    logic [DW-1:0]     s_data;
    logic              m_valid;
    logic              m_ready;
    logic [VW-1:0]     m_data;
    logic              busy;

    int checks = 0;
    int errors = 0;
    logic [VW-1:0] sb[$];
    logic [VW-1:0] exp_vec;

    localparam logic [DW-1:0] A = 64'h0123456789ABCDEF;
    localparam logic [DW-1:0] B = 64'hFEDCBA9876543210;
    localparam logic [DW-1:0] C = 64'h5555AAAA5555AAAA;
    localparam logic [DW-1:0] D = 64'h8000000000000001;

    unpack_and_expand #(.K(K), .data_width(DW)) dut (
        .clk         (clk),
        .aresetn     (aresetn),
        .data_select (data_select),
        .signed_mode (signed_mode),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference expansion: lane i <- element (i mod E) of word (i div E).
    function automatic logic [VW-1:0] model(input logic [PREC_W-1:0] sel, input logic sgn,
                                            input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                                            input logic [DW-1:0] w2, input logic [DW-1:0] w3);
        logic [DW-1:0] wd[4];
        logic [VW-1:0] r;
        logic [DW-1:0] v;
        int p;
        int e;
        wd[0] = w0; wd[1] = w1; wd[2] = w2; wd[3] = w3;
        r = '0;
        if      (sel == SEL_INT8)  p = 8;
        else if (sel == SEL_INT16) p = 16;
        else if (sel == SEL_INT32) p = 32;
        else if (sel == SEL_INT64) p = 64;
        else                       p = 0;
        if (p == 0) return r;
        e = DW / p;
        for (int i = 0; i < K; i++) begin
            v = wd[i / e] >> ((i % e) * p);
            case (p)
                8:  v = sgn ? {{56{v[7]}},  v[7:0]}  : {56'd0, v[7:0]};
                16: v = sgn ? {{48{v[15]}}, v[15:0]} : {48'd0, v[15:0]};
                32: v = sgn ? {{32{v[31]}}, v[31:0]} : {32'd0, v[31:0]};
                default: ;
            endcase
            r[i*DW +: DW] = v;
        end
        return r;
    endfunction

    // Offer one word and wait (bounded) until it is taken; returns 1 ns after
    // the accepting edge.
    task automatic send_word(input logic [DW-1:0] d, input logic [PREC_W-1:0] sel,
                             input logic sgn);
        int n = 0;
        s_valid     = 1'b1;
        s_data      = d;
        data_select = sel;
        signed_mode = sgn;
        @(negedge clk);
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) chk("accept_timeout", s_ready, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_data  = {$urandom, $urandom};
    endtask

    // Scoreboard: every completed handshake pops one expected vector.
    always @(negedge clk) begin
        if (aresetn && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", m_valid, 0);
            end else begin
                exp_vec = sb.pop_front();
                chk("vector", m_data, exp_vec);
            end
        end
    end

    initial begin
        logic [PREC_W-1:0] bad_sel;
        int n;
        bad_sel     = 3'd5;
        clk         = 1'b0;
        aresetn     = 1'b0;
        s_valid     = 1'b0;
        s_data      = '0;
        data_select = SEL_INT8;
        signed_mode = 1'b0;
        m_ready     = 1'b1;

        #3;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy",    busy,    0);
        chk("rst_m_data",  m_data,  0);
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
        #1;
        chk("rel_s_ready_pre_edge", s_ready, 0);
        @(posedge clk);
        #1;
        chk("rel_s_ready", s_ready, 1);
        chk("rel_busy",    busy,    0);

        // INT8 unsigned: single word, upper bytes discarded
        sb.push_back({64'd4, 64'd3, 64'd2, 64'd1});
        send_word(64'h0807060504030201, SEL_INT8, 1'b0);
        chk("int8_lat_valid", m_valid, 1);
        chk("int8_s_ready",   s_ready, 0);

        // INT8 signed
        sb.push_back(model(SEL_INT8, 1'b1, 64'h0000000080FF7F01, '0, '0, '0));
        send_word(64'h0000000080FF7F01, SEL_INT8, 1'b1);
        chk("int8s_lat_valid", m_valid, 1);

        // INT16 signed
        sb.push_back({64'hFFFFFFFFFFFFFFFF, 64'd3, 64'hFFFFFFFFFFFF8000, 64'd1});
        send_word(64'hFFFF000380000001, SEL_INT16, 1'b1);
        chk("int16s_lat_valid", m_valid, 1);

        // INT32 unsigned, two words
        sb.push_back({64'd4, 64'd3, 64'd2, 64'd1});
        send_word(64'h0000000200000001, SEL_INT32, 1'b0);
        chk("int32_w0_valid", m_valid, 0);
        chk("int32_w0_busy",  busy,    1);
        send_word(64'h0000000400000003, SEL_INT32, 1'b0);
        chk("int32_w1_valid", m_valid, 1);

        // INT32 signed; signed_mode dropped on the second word is ignored
        sb.push_back(model(SEL_INT32, 1'b1, 64'h80000000FFFFFFFF, 64'h000000017FFFFFFF, '0, '0));
        send_word(64'h80000000FFFFFFFF, SEL_INT32, 1'b1);
        send_word(64'h000000017FFFFFFF, SEL_INT32, 1'b0);
        chk("int32s_valid", m_valid, 1);

        // INT64, four words; data_select switched to INT8 after word 1
        sb.push_back({D, C, B, A});
        send_word(A, SEL_INT64, 1'b0);
        chk("int64_w0_valid", m_valid, 0);
        send_word(B, SEL_INT8, 1'b1);
        chk("int64_w1_valid", m_valid, 0);
        send_word(C, SEL_INT8, 1'b1);
        chk("int64_w2_valid", m_valid, 0);
        send_word(D, SEL_INT8, 1'b1);
        chk("int64_w3_valid", m_valid, 1);

        // Invalid precision code: one word, all-zero vector
        sb.push_back('0);
        send_word(64'hFFFFFFFFFFFFFFFF, bad_sel, 1'b1);
        chk("invalid_valid", m_valid, 1);

        // Backpressure: hold for 5 cycles with a stray word offered
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        sb.push_back({64'h1234, 64'hABCD, 64'h0, 64'hFFFF});
        send_word(64'h1234ABCD0000FFFF, SEL_INT16, 1'b0);
        chk("bp_valid", m_valid, 1);
        s_valid     = 1'b1;
        s_data      = 64'hDEADBEEFDEADBEEF;
        data_select = SEL_INT8;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_s_ready", s_ready, 0);
            chk("bp_m_valid", m_valid, 1);
            chk("bp_m_data",  m_data,  {64'h1234, 64'hABCD, 64'h0, 64'hFFFF});
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_idle_busy",  busy,    0);
        chk("bp_idle_valid", m_valid, 0);
        chk("bp_idle_ready", s_ready, 1);

        // Reset after first INT32 word: partial vector discarded
        send_word(64'h0000002200000011, SEL_INT32, 1'b0);
        chk("rstmid_pre_valid", m_valid, 0);
        #2;
        aresetn = 1'b0;
        #1;
        chk("rstmid_m_data",  m_data,  0);
        chk("rstmid_m_valid", m_valid, 0);
        chk("rstmid_busy",    busy,    0);
        chk("rstmid_s_ready", s_ready, 0);
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        @(posedge clk);
        #1;
        chk("rstmid_rel_ready", s_ready, 1);
        sb.push_back({64'd8, 64'd7, 64'd6, 64'd5});
        send_word(64'h0000000600000005, SEL_INT32, 1'b0);
        chk("post_rst_w0_valid", m_valid, 0);
        send_word(64'h0000000800000007, SEL_INT32, 1'b0);
        chk("post_rst_w1_valid", m_valid, 1);

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drain", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/unpack_and_expand.md
UNPACK_AND_EXPAND -- requirements
Module: unpack_and_expand

Interface
REQ-001 Parameters SHALL be:
- K, default 4, number of output lanes.
- data_width, default 64, lane and packed-word width in bits.
REQ-002 Ports SHALL be:
- clk, input, 1, sole clock; all state changes on its rising edge.
- aresetn, input, 1, asynchronous active-low reset.
- data_select, input, `LOG_ALLOWED_PRECISIONS, precision code (`INT8/`INT16/`INT32/`INT64).
- signed_mode, input, 1, 1 = sign-extend elements, 0 = zero-extend.
- s_valid, input, 1, packed word offered.
- s_ready, output, 1, packed word accepted when s_valid && s_ready.
- s_data, input, data_width, packed word with element 0 in the LSBs.
- m_valid, output, 1, expanded vector available.
- m_ready, input, 1, vector consumed when m_valid && m_ready.
- m_data, output, K*data_width, lane i in bits [data_width*(i+1)-1 : data_width*i].
- busy, output, 1, high whenever state is not IDLE.

Function
REQ-003 Block SHALL be the inverse of the precision compactor: it takes packed P-bit elements and distributes them one per lane.
REQ-004 Element size P SHALL be 8, 16, 32 or 64 per data_select; elements per word E = data_width/P.
REQ-005 Words per vector W SHALL be ceil(K/E), e.g. K=4, data_width=64 gives W=1, 1, 2, 4 for INT8/16/32/64.
REQ-006 FSM states SHALL be IDLE, COLLECT and HOLD.
REQ-007 IDLE behaviour:
- s_ready=1.
- On the first accepted word, latch data_select and signed_mode, write that word, then go to COLLECT, or to HOLD if W=1.
REQ-008 COLLECT behaviour:
- s_ready=1; one word accepted per cycle that s_valid=1.
- Word counter w increments per accepted word.
- After word W-1 is accepted, go to HOLD.
REQ-009 Element j of word w SHALL be written to lane w*E+j, extended to data_width per the latched signed_mode.
REQ-010 Elements whose lane index is >= K SHALL be discarded.
REQ-011 HOLD behaviour:
- m_valid=1 and s_ready=0.
- m_data held stable until m_ready=1, then go to IDLE.
REQ-012 Latency: m_valid SHALL rise in the cycle after the last word of a vector is accepted; throughput is one vector per W+1 cycles.
REQ-013 data_select and signed_mode changes after the first word of a vector SHALL have no effect until the next vector.
REQ-014 An invalid data_select code SHALL consume one word and emit an all-zero vector, with W=1.
REQ-015 When entering COLLECT from IDLE, all lanes not yet written SHALL read as zero.
REQ-016 s_valid while s_ready=0 SHALL NOT be accepted, and s_data SHALL be ignored.
REQ-017 m_ready while m_valid=0 SHALL have no effect.

Reset
REQ-018 While aresetn=0, the following SHALL hold immediately and asynchronously:
- State = IDLE, w = 0.
- m_data = 0, m_valid = 0, busy = 0, s_ready = 0.
REQ-019 After aresetn deasserts, s_ready SHALL become 1 in IDLE on the next clk edge.
REQ-020 Reset mid-vector SHALL discard the partial vector; no m_valid pulse results.

Structure
REQ-021 Precision codes and `LOG_ALLOWED_PRECISIONS SHALL come from the shared precision_def.vh header; no local redefinition is permitted.
REQ-022 Per-precision extraction and extension SHALL be one sub-module, element_extend, which takes a word, element index, precision and signed_mode and returns a data_width value.

Verification (K=4, data_width=64)
REQ-023 The bench SHALL cover these directed scenarios:
- INT8 unsigned, s_data=0x0807060504030201 -> one cycle later m_valid=1, lanes 0..3 = 1, 2, 3, 4; bytes 5..8 discarded.
- INT16 signed, s_data=0xFFFF000380000001 -> lane0=1, lane1=0xFFFFFFFFFFFF8000, lane2=3, lane3=0xFFFFFFFFFFFFFFFF.
- INT32 unsigned, words 0x0000000200000001 then 0x0000000400000003 -> lanes 1, 2, 3, 4; m_valid only after the second word.
- INT64, four words A, B, C, D -> lanes A, B, C, D; data_select changed to INT8 after word 1 has no effect.
- Backpressure: m_ready=0 for 5 cycles in HOLD -> s_ready=0, m_data constant; m_ready=1 -> IDLE next cycle.
- INT32, aresetn pulsed low after word 1 -> outputs zero at once; next vector decodes correctly with no stale lanes.
